// File: rtl/interp_ratio_if.sv
// Sample/output bundle for interp_ratio: the upsampler's input handshake and its
// interpolated output stream, grouped so a bench or parent connects it in one go.
interface interp_ratio_if #(
    parameter int WIDTH = 20
);
    // in_valid/in_ready: a sample transfers on the rising clock edge where both are
    // high. in_ready rises only on the phase tick; in_valid may be raised at any time
    // and held, and does not wait for in_ready. A tick without in_valid is an underrun.
    logic                    enable;
    logic                    mode;
    logic signed [WIDTH-1:0] v_in;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] interp_o;
    logic                    out_valid;
    logic                    frame_o;
    logic                    underrun;
    logic [7:0]              underrun_cnt;

    modport master (
        output enable, mode, v_in, in_valid,
        input  in_ready, interp_o, out_valid, frame_o, underrun, underrun_cnt
    );

    modport slave (
        input  enable, mode, v_in, in_valid,
        output in_ready, interp_o, out_valid, frame_o, underrun, underrun_cnt
    );
endinterface

// File: rtl/interp_ratio.sv
// Integer-ratio upsampler: RATIO output cycles per input sample, linear interpolation
// (mode=0) or zero-order hold (mode=1) from a fixed-point accumulator.
module interp_ratio #(
    parameter int WIDTH = 20,
    parameter int RATIO = 50,
    parameter int FRAC  = 16
) (
    input logic         clock,
    input logic         reset_n,
    interp_ratio_if.slave bus
);
    localparam int PHW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int ACCW  = WIDTH + FRAC + 2;
    localparam int PRODW = WIDTH + 1 + 65;

    // Reciprocal of RATIO with 16 guard bits; the step multiply replaces a divider.
    localparam logic [63:0] RECIP = ((64'd1 << (FRAC + 16)) + 64'(RATIO / 2)) / 64'(RATIO);

    localparam longint              MAXL  = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
    localparam logic signed [WIDTH+1:0] MAX_Q = (WIDTH + 2)'(MAXL);
    localparam logic signed [WIDTH+1:0] MIN_Q = (WIDTH + 2)'(-MAXL - 64'sd1);
    localparam logic signed [WIDTH-1:0] MAX_O = WIDTH'(MAXL);
    localparam logic signed [WIDTH-1:0] MIN_O = WIDTH'(-MAXL - 64'sd1);

    logic [PHW-1:0]          phase;
    logic signed [WIDTH-1:0] v_prev;
    logic signed [WIDTH-1:0] v_cur;
    logic signed [ACCW-1:0]  acc;
    logic signed [WIDTH-1:0] interp_q;
    logic                    out_valid_q;
    logic                    frame_q;
    logic                    underrun_q;
    logic [7:0]              underrun_cnt_q;

    logic                    tick;
    logic signed [WIDTH:0]   diff;
    logic signed [PRODW-1:0] prod;
    logic signed [ACCW-1:0]  step;
    logic signed [ACCW-1:0]  acc_next;
    logic signed [WIDTH+1:0] acc_q;
    logic signed [WIDTH-1:0] interp_next;

    assign tick = bus.enable && (phase == PHW'(RATIO - 1));

    // One extra bit keeps full-scale differences from wrapping.
    assign diff = {v_cur[WIDTH-1], v_cur} - {v_prev[WIDTH-1], v_prev};
    assign prod = PRODW'(diff) * $signed(PRODW'({1'b0, RECIP}));
    assign step = bus.mode ? '0 : ACCW'(prod >>> 16);

    // Reload on tick makes every segment start exactly on a sample value.
    always_comb begin
        acc_next = acc;
        if (bus.enable) begin
            if (tick) begin
                acc_next = ACCW'(v_cur) <<< FRAC;
            end else begin
                acc_next = acc + step;
            end
        end
    end

    assign acc_q = (WIDTH + 2)'(acc_next >>> FRAC);

    always_comb begin
        interp_next = WIDTH'(acc_q);
        if (acc_q > MAX_Q) begin
            interp_next = MAX_O;
        end else if (acc_q < MIN_Q) begin
            interp_next = MIN_O;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase          <= '0;
            v_prev         <= '0;
            v_cur          <= '0;
            acc            <= '0;
            interp_q       <= '0;
            out_valid_q    <= 1'b0;
            frame_q        <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            out_valid_q <= bus.enable;
            frame_q     <= tick;
            if (bus.enable) begin
                phase    <= tick ? '0 : phase + 1'b1;
                acc      <= acc_next;
                interp_q <= interp_next;
            end
            if (tick) begin
                v_prev <= v_cur;
                if (bus.in_valid) begin
                    v_cur <= bus.v_in;
                end else begin
                    underrun_q <= 1'b1;
                    if (underrun_cnt_q != 8'hFF) begin
                        underrun_cnt_q <= underrun_cnt_q + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.in_ready     = tick;
    assign bus.interp_o     = interp_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.frame_o      = frame_q;
    assign bus.underrun     = underrun_q;
    assign bus.underrun_cnt = underrun_cnt_q;
endmodule

// File: doc/interp_ratio.md
INTERP_RATIO -- requirements
Module: interp_ratio

Interface
REQ-001 SHALL have parameter WIDTH, default 20, signed sample width (8..32).
REQ-002 SHALL have parameter RATIO, default 50, output cycles per input sample (2..1024).
REQ-003 SHALL have parameter FRAC, default 16, fractional bits of the interpolation accumulator (8..24).
REQ-004 SHALL have port clock  in  1  single block clock.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  in  1  advances phase counter when high.
REQ-007 SHALL have port mode  in  1  0 = linear interpolation, 1 = zero-order hold.
REQ-008 SHALL have port v_in  in  WIDTH  signed input sample.
REQ-009 SHALL have port in_valid  in  1  v_in valid.
REQ-010 SHALL have port in_ready  out  1  sample accepted this cycle (combinational).
REQ-011 SHALL have port interp_o  out  WIDTH  signed interpolated output, registered.
REQ-012 SHALL have port out_valid  out  1  interp_o is a new output this cycle, registered.
REQ-013 SHALL have port frame_o  out  1  interp_o equals an input sample exactly (segment start), registered.
REQ-014 SHALL have port underrun  out  1  sticky: a sample tick occurred without in_valid.
REQ-015 SHALL have port underrun_cnt  out  8  saturating count of underruns.

Function
REQ-016 Phase counter SHALL count 0..RATIO-1 while enable=1, wrap to 0, and hold while enable=0; tick = enable & (phase == RATIO-1).
REQ-017 in_ready SHALL equal tick; a sample is accepted only when tick & in_valid.
REQ-018 On tick: v_prev <= v_cur; v_cur <= v_in if in_valid, else v_cur unchanged.
REQ-019 On tick without in_valid: underrun <= 1, underrun_cnt increments, saturating at 255.
REQ-020 diff SHALL be computed as v_cur - v_prev at WIDTH+1 bits signed; no wrap for any input pair.
REQ-021 step SHALL be round(diff * 2^FRAC / RATIO), implemented as (diff * RECIP) >>> 16, RECIP = round(2^(FRAC+16) / RATIO), an elaboration-time constant; no runtime divider.
REQ-022 step SHALL be forced to 0 when mode=1.
REQ-023 Accumulator SHALL be WIDTH+FRAC+2 bits signed; on tick, acc <= v_cur << FRAC (pre-update v_cur); other enabled cycles, acc <= acc + step.
REQ-024 interp_o SHALL be acc >>> FRAC, clamped to the signed WIDTH range.
REQ-025 Latency: an accepted sample SHALL appear exactly on interp_o RATIO+1 cycles after the accepting tick, with frame_o=1.
REQ-026 Between frames, |interp_o - ideal linear value| SHALL be <= 1 LSB; segment endpoints SHALL be exact via reload (REQ-023).
REQ-027 out_valid SHALL be registered enable; frame_o SHALL be registered tick.
REQ-028 While enable=0: acc, phase, v_prev, v_cur and interp_o SHALL hold; out_valid=0; frame_o=0.
REQ-029 A mode change mid-segment SHALL take effect on the next cycle; the accumulator SHALL NOT be reloaded.

Reset
REQ-030 reset_n low SHALL asynchronously clear phase, v_prev, v_cur, acc, interp_o, out_valid, frame_o, underrun and underrun_cnt to 0.
REQ-031 Reset asserted mid-segment SHALL abort the segment; after release, phase restarts at 0 and the first tick occurs RATIO cycles later.

Verification
REQ-032 Ramp, defaults, mode=0: v_in = 0 then 50000 on consecutive ticks -> following segment interp_o = 0,1000,2000,...,49000, then 50000 with frame_o=1.
REQ-033 Full-scale step, WIDTH=20: samples -524288 then 524287 -> monotonic non-decreasing output, no wrap, ends at exactly 524287.
REQ-034 Hold: mode=1 with the same samples as REQ-032 -> interp_o = 0 for 50 cycles, then 50000 held for 50 cycles.
REQ-035 Underrun: in_valid=0 on 300 consecutive ticks -> underrun=1, underrun_cnt=255, interp_o flat at the last sample.
REQ-036 Enable gap: enable=0 for 7 cycles mid-segment -> outputs frozen, out_valid=0; segment resumes and ends on the same value, 7 cycles later.
REQ-037 Async reset: reset_n pulsed low between clock edges mid-ramp -> all outputs 0 immediately; first frame_o RATIO+1 cycles after release.
